// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply controller that drives the shared LEGv8 ALU.
// Produces the low N bits of a_in * b_in; the ALU does all arithmetic.
module alu_mul_sequencer #(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    output logic [4:0]   alu_FS,
    output logic         alu_C0,
    input  logic [N-1:0] alu_F,
    input  logic [3:0]   alu_status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    localparam logic [4:0] FS_IDLE = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b01000;
    localparam logic [4:0] FS_SHL  = 5'b10000;
    localparam logic [4:0] FS_SHR  = 5'b10100;

    state_t       state_q, state_d;
    logic [N-1:0] m_q, m_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] p_q, p_d;
    logic [N-1:0] product_q, product_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // Only the Z flag steers the sequence; V, C and N are don't-care.
    logic status_unused;
    assign status_unused = ^alu_status[3:1];

    // Next-state and datapath register updates; ALU result is written back per step.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        p_d       = p_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d = a_in;
                    q_d = b_in;
                    p_d = '0;
                    if (b_in == '0) begin
                        state_d = S_DONE;
                    end else if (b_in[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHL;
                    end
                end
            end
            S_ADD: begin
                p_d     = alu_F;
                state_d = S_SHL;
            end
            S_SHL: begin
                m_d     = alu_F;
                state_d = S_SHR;
            end
            S_SHR: begin
                q_d = alu_F;
                if (alu_status[0]) begin
                    state_d = S_DONE;
                end else if (alu_F[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Capture the finished partial product as DONE is entered.
        if (state_d == S_DONE && state_q != S_DONE) begin
            product_d = p_d;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // ALU operand/function selection decoded from the current state.
    always_comb begin
        alu_A  = '0;
        alu_B  = '0;
        alu_FS = FS_IDLE;
        unique case (state_q)
            S_ADD: begin
                alu_A  = p_q;
                alu_B  = m_q;
                alu_FS = FS_ADD;
            end
            S_SHL: begin
                alu_A  = m_q;
                alu_B  = N'(1);
                alu_FS = FS_SHL;
            end
            S_SHR: begin
                alu_A  = q_q;
                alu_B  = N'(1);
                alu_FS = FS_SHR;
            end
            default: begin
                alu_A  = '0;
                alu_B  = '0;
                alu_FS = FS_IDLE;
            end
        endcase
    end

    assign alu_C0  = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

    // State and datapath registers with synchronous reset discarding any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            p_q       <= p_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural LEGv8 ALU beside it.
// Expected latencies and products are hand-computed constants.
module tb_alu_mul_sequencer;

    localparam int N = 64;

    logic         clock;
    logic         reset;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic [N-1:0] alu_A;
    logic [N-1:0] alu_B;
    logic [4:0]   alu_FS;
    logic         alu_C0;
    logic [N-1:0] alu_F;
    logic [3:0]   alu_status;

    int n_checks;
    int n_fail;

    logic [4:0] fs_log [0:15];
    int         done_cyc;
    int         busy_gap;
    int         fs_any;
    int         c0_bad;
    int         done_cnt;
    logic [N-1:0] prod_seen;

    alu_mul_sequencer #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_FS     (alu_FS),
        .alu_C0     (alu_C0),
        .alu_F      (alu_F),
        .alu_status (alu_status)
    );

    // Combinational ALU model for the three functions the sequencer uses.
    always_comb begin
        alu_F = '0;
        case (alu_FS)
            5'b01000: alu_F = alu_A + alu_B + {{(N-1){1'b0}}, alu_C0};
            5'b10000: alu_F = alu_A << alu_B[5:0];
            5'b10100: alu_F = alu_A >> alu_B[5:0];
            default:  alu_F = '0;
        endcase
        alu_status = {2'b00, alu_F[N-1], (alu_F == '0)};
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start (sampled at the next posedge = cycle 0), then watch cycles
    // until done. With poke set, start is re-asserted with other operands in
    // cycle 1 and in the DONE cycle.
    task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit poke);
        int cyc;
        @(negedge clock);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc       = 0;
        done_cyc  = 0;
        busy_gap  = 0;
        fs_any    = 0;
        c0_bad    = 0;
        done_cnt  = 0;
        prod_seen = '0;
        for (int i = 0; i < 16; i++) fs_log[i] = 5'b11111;
        while (done_cyc == 0 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (cyc < 16) fs_log[cyc] = alu_FS;
            if (alu_FS != 5'b00000) fs_any = 1;
            if (alu_C0 !== 1'b0) c0_bad++;
            if (!busy) busy_gap++;
            if (done) begin
                done_cyc  = cyc;
                prod_seen = product;
            end
            if (poke && (cyc == 1 || done)) begin
                a_in  = 64'd9;
                b_in  = 64'd11;
                start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", product, 64'd0);
        chk("rst_fs", 64'(alu_FS), 64'd0);
        chk("rst_A", alu_A, 64'd0);
        chk("rst_B", alu_B, 64'd0);
        reset = 1'b0;

        // 3 x 5
        run_mul(64'd3, 64'd5, 1'b0);
        chk("b_lat", 64'(done_cyc), 64'd9);
        chk("b_prod", prod_seen, 64'd15);
        chk("b_busy", 64'(busy_gap), 64'd0);
        chk("b_c0", 64'(c0_bad), 64'd0);
        chk("b_fs1", 64'(fs_log[1]), 64'b01000);
        chk("b_fs2", 64'(fs_log[2]), 64'b10000);
        chk("b_fs3", 64'(fs_log[3]), 64'b10100);
        chk("b_fs4", 64'(fs_log[4]), 64'b10000);
        chk("b_fs5", 64'(fs_log[5]), 64'b10100);
        chk("b_fs6", 64'(fs_log[6]), 64'b01000);
        chk("b_fs7", 64'(fs_log[7]), 64'b10000);
        chk("b_fs8", 64'(fs_log[8]), 64'b10100);
        chk("b_fs9", 64'(fs_log[9]), 64'b00000);
        @(negedge clock);
        chk("b_idle_busy", 64'(busy), 64'd0);
        chk("b_idle_done", 64'(done), 64'd0);
        chk("b_hold_prod", product, 64'd15);

        // 0xDEAD x 0
        run_mul(64'hDEAD, 64'd0, 1'b0);
        chk("z_lat", 64'(done_cyc), 64'd1);
        chk("z_prod", prod_seen, 64'd0);
        chk("z_nofs", 64'(fs_any), 64'd0);

        // 0 x 0x13: bits 1,1,0,0,1 -> 3+3+2+2+3 + 1
        run_mul(64'd0, 64'h13, 1'b0);
        chk("a0_lat", 64'(done_cyc), 64'd14);
        chk("a0_prod", prod_seen, 64'd0);

        // all ones squared wraps to 1
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("w_lat", 64'(done_cyc), 64'd193);
        chk("w_prod", prod_seen, 64'd1);
        chk("w_busy", 64'(busy_gap), 64'd0);

        // top bit only
        run_mul(64'd1, 64'h8000_0000_0000_0000, 1'b0);
        chk("t_lat", 64'(done_cyc), 64'd130);
        chk("t_prod", prod_seen, 64'h8000_0000_0000_0000);

        // ignored starts in ADD and DONE, operands changed after acceptance
        run_mul(64'd3, 64'd5, 1'b1);
        chk("i_lat", 64'(done_cyc), 64'd9);
        chk("i_prod", prod_seen, 64'd15);
        @(negedge clock);
        chk("i_idle1", 64'(busy), 64'd0);
        @(negedge clock);
        chk("i_idle2", 64'(busy), 64'd0);
        chk("i_idle_prod", product, 64'd15);

        // reset asserted in cycle 4 of 3 x 5
        @(negedge clock);
        a_in  = 64'd3;
        b_in  = 64'd5;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_done", 64'(done), 64'd0);
        chk("r_prod", product, 64'd0);
        chk("r_fs", 64'(alu_FS), 64'd0);
        @(negedge clock);
        chk("r_stay_idle", 64'(busy), 64'd0);

        // 7 x 6: bits 0,1,1 -> 2+3+3 + 1
        run_mul(64'd7, 64'd6, 1'b0);
        chk("r_lat", 64'(done_cyc), 64'd9);
        chk("r_prod2", prod_seen, 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
